// File: rtl/conv_img_loader.sv
// conv_img_loader: write-side front end for the single-layer conv engine.
// Collects a serial pixel stream (valid/ready) into the flat D*H*W image bus,
// releases the conv layer's reset once a frame is complete and holds the image
// stable until the consumer acknowledges it.
//
// Optional build macro: CONV_IMG_LOADER_DBUF_EN adds a shadow buffer so the
// next frame can stream in while the current one is being consumed.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   s_valid/s_ready   pixel stream handshake
//   s_data, s_last    pixel value, end-of-frame marker
//   img               assembled image, element k at img[k*DATA_WIDTH +: DATA_WIDTH]
//   img_valid         img holds a complete frame
//   conv_rst          reset for the conv layer, high while no frame is held
//   img_ack           consumer pulse: frame consumed
//   frame_err         sticky framing error
//   frame_cnt         completed frame counter (wraps)
module conv_img_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned D          = 1,
  parameter int unsigned H          = 32,
  parameter int unsigned W          = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic                           s_last,
  output logic [0:D*H*W*DATA_WIDTH-1]    img,
  output logic                           img_valid,
  output logic                           conv_rst,
  input  logic                           img_ack,
  output logic                           frame_err,
  output logic [15:0]                    frame_cnt
);

  localparam int unsigned N     = D * H * W;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {FILL, FULL} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    img_valid_q, img_valid_d;
  logic                    conv_rst_q, conv_rst_d;
  logic                    s_ready_q, s_ready_d;
  logic                    frame_err_q, frame_err_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [N];
  logic                    wr_en;
  logic                    beat;

`ifdef CONV_IMG_LOADER_DBUF_EN
  logic [DATA_WIDTH-1:0]   sh_q [N];
  logic [IDX_W-1:0]        sh_idx_q, sh_idx_d, sh_idx_n;
  logic                    sh_full_q, sh_full_d, sh_full_n;
  logic                    sh_wr;
  logic                    copy_en;
`endif

  assign beat = s_valid && s_ready_q;

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    img_valid_d = img_valid_q;
    conv_rst_d  = conv_rst_q;
    s_ready_d   = s_ready_q;
    frame_err_d = frame_err_q;
    frame_cnt_d = frame_cnt_q;
    wr_en       = 1'b0;
`ifdef CONV_IMG_LOADER_DBUF_EN
    sh_idx_d    = sh_idx_q;
    sh_full_d   = sh_full_q;
    sh_idx_n    = sh_idx_q;
    sh_full_n   = sh_full_q;
    sh_wr       = 1'b0;
    copy_en     = 1'b0;
`endif

    if (state_q == FILL) begin
      // img_ack is ignored while filling
      if (beat) begin
        wr_en = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          state_d     = FULL;
          img_valid_d = 1'b1;
          conv_rst_d  = 1'b0;
`ifdef CONV_IMG_LOADER_DBUF_EN
          s_ready_d   = 1'b1;
`else
          s_ready_d   = 1'b0;
`endif
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (!s_last) frame_err_d = 1'b1;
        end else if (s_last) begin
          // early last: drop the partial frame and restart at element 0
          frame_err_d = 1'b1;
          idx_d       = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    end else begin
`ifdef CONV_IMG_LOADER_DBUF_EN
      // conv_rst is only a one-cycle restart pulse while FULL
      conv_rst_d = 1'b0;
      if (beat) begin
        sh_wr = 1'b1;
        if (sh_idx_q == LAST_IDX) begin
          sh_idx_n    = '0;
          sh_full_n   = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (!s_last) frame_err_d = 1'b1;
        end else if (s_last) begin
          frame_err_d = 1'b1;
          sh_idx_n    = '0;
        end else begin
          sh_idx_n = sh_idx_q + IDX_W'(1);
        end
      end
      s_ready_d = !sh_full_n;
      sh_idx_d  = sh_idx_n;
      sh_full_d = sh_full_n;
      if (img_ack) begin
        // shadow moves into img; a partial shadow continues filling in place
        copy_en   = 1'b1;
        sh_full_d = 1'b0;
        sh_idx_d  = '0;
        s_ready_d = 1'b1;
        conv_rst_d = 1'b1;
        if (!sh_full_n) begin
          state_d     = FILL;
          img_valid_d = 1'b0;
          idx_d       = sh_idx_n;
        end
      end
`else
      if (img_ack) begin
        state_d     = FILL;
        img_valid_d = 1'b0;
        conv_rst_d  = 1'b1;
        s_ready_d   = 1'b1;
      end
`endif
    end
  end

  // State, control and image registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      img_valid_q <= 1'b0;
      conv_rst_q  <= 1'b1;
      s_ready_q   <= 1'b1;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
      for (int k = 0; k < N; k++) mem_q[k] <= '0;
`ifdef CONV_IMG_LOADER_DBUF_EN
      sh_idx_q  <= '0;
      sh_full_q <= 1'b0;
      for (int k = 0; k < N; k++) sh_q[k] <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      img_valid_q <= img_valid_d;
      conv_rst_q  <= conv_rst_d;
      s_ready_q   <= s_ready_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
      if (wr_en) mem_q[idx_q] <= s_data;
`ifdef CONV_IMG_LOADER_DBUF_EN
      sh_idx_q  <= sh_idx_d;
      sh_full_q <= sh_full_d;
      if (sh_wr) sh_q[sh_idx_q] <= s_data;
      // a beat landing on the ack edge is merged into the copy
      if (copy_en) begin
        for (int k = 0; k < N; k++)
          mem_q[k] <= (sh_wr && (sh_idx_q == IDX_W'(k))) ? s_data : sh_q[k];
      end
`endif
    end
  end

  // Flatten element array onto the ascending image bus
  always_comb begin
    img = '0;
    for (int k = 0; k < N; k++) img[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k];
  end

  assign s_ready   = s_ready_q;
  assign img_valid = img_valid_q;
  assign conv_rst  = conv_rst_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_conv_img_loader.sv
// Directed bench for conv_img_loader: a 1x4x4 instance for framing/handshake
// behaviour and a 2x4x4 instance for channel ordering under stream gaps.
module tb_conv_img_loader;

  localparam int unsigned DW = 32;
  localparam int unsigned N1 = 16;
  localparam int unsigned N2 = 32;

  logic clk, rst;

  logic             s_valid, s_ready, s_last, img_valid, conv_rst, img_ack, frame_err;
  logic [DW-1:0]    s_data;
  logic [0:N1*DW-1] img;
  logic [15:0]      frame_cnt;

  logic             s_valid2, s_ready2, s_last2, img_valid2, conv_rst2, img_ack2, frame_err2;
  logic [DW-1:0]    s_data2;
  logic [0:N2*DW-1] img2;
  logic [15:0]      frame_cnt2;

  int n_checks = 0;
  int n_err    = 0;
  int cnt_base;

  conv_img_loader #(.DATA_WIDTH(DW), .D(1), .H(4), .W(4)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .img(img), .img_valid(img_valid), .conv_rst(conv_rst),
    .img_ack(img_ack), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  conv_img_loader #(.DATA_WIDTH(DW), .D(2), .H(4), .W(4)) u_dut2 (
    .clk(clk), .rst(rst), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .s_last(s_last2), .img(img2), .img_valid(img_valid2), .conv_rst(conv_rst2),
    .img_ack(img_ack2), .frame_err(frame_err2), .frame_cnt(frame_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] el1(input int k);
    return img[k*DW +: DW];
  endfunction

  function automatic logic [31:0] el2(input int k);
    return img2[k*DW +: DW];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    step();
    s_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    img_ack = 1'b1;
    step();
    img_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int k;
    int cyc;
    logic acc;
    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; img_ack = 1'b0;
    s_valid2 = 1'b0; s_data2 = '0; s_last2 = 1'b0; img_ack2 = 1'b0;

    // Reset values
    step();
    step();
    chk("rst_img_valid", 32'(img_valid), 0);
    chk("rst_conv_rst", 32'(conv_rst), 1);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_img_el0", el1(0), 0);
    rst = 1'b0;
    step();
    chk("rst_s_ready", 32'(s_ready), 1);

    // Back-to-back frame, checking the completion edge
    for (int i = 0; i < 15; i++) beat(32'h100 + 32'(i), 1'b0);
    chk("f1_valid_before_last", 32'(img_valid), 0);
    chk("f1_conv_rst_before_last", 32'(conv_rst), 1);
    beat(32'h10F, 1'b1);
    chk("f1_img_valid", 32'(img_valid), 1);
    chk("f1_conv_rst", 32'(conv_rst), 0);
`ifdef CONV_IMG_LOADER_DBUF_EN
    chk("f1_s_ready", 32'(s_ready), 1);
`else
    chk("f1_s_ready", 32'(s_ready), 0);
`endif
    chk("f1_frame_cnt", 32'(frame_cnt), 1);
    chk("f1_frame_err", 32'(frame_err), 0);
    for (int i = 0; i < 16; i++) chk("f1_elem", el1(i), 32'h100 + 32'(i));

`ifdef CONV_IMG_LOADER_DBUF_EN
    // Second frame into the shadow while the first is held
    for (int i = 0; i < 16; i++) beat(32'h700 + 32'(i), i == 15);
    chk("db_s_ready_full", 32'(s_ready), 0);
    chk("db_frame_cnt", 32'(frame_cnt), 2);
    chk("db_img_held", el1(0), 32'h100);
    chk("db_img_valid_held", 32'(img_valid), 1);
    pulse_ack();
    chk("db_swap_el0", el1(0), 32'h700);
    chk("db_swap_el15", el1(15), 32'h70F);
    chk("db_swap_valid", 32'(img_valid), 1);
    chk("db_swap_conv_rst", 32'(conv_rst), 1);
    chk("db_swap_s_ready", 32'(s_ready), 1);
    step();
    chk("db_conv_rst_pulse_end", 32'(conv_rst), 0);
    chk("db_valid_after_pulse", 32'(img_valid), 1);
    pulse_ack();
    chk("db_empty_ack_valid", 32'(img_valid), 0);
    chk("db_empty_ack_conv_rst", 32'(conv_rst), 1);
    cnt_base = 2;
`else
    // Hold FULL with the source pushing: nothing may be accepted
    s_valid = 1'b1; s_data = 32'hDEAD; s_last = 1'b0;
    for (int i = 0; i < 30; i++) step();
    chk("hold_el0", el1(0), 32'h100);
    chk("hold_el15", el1(15), 32'h10F);
    chk("hold_frame_cnt", 32'(frame_cnt), 1);
    chk("hold_img_valid", 32'(img_valid), 1);
    pulse_ack();
    s_valid = 1'b0;
    chk("ack_img_valid", 32'(img_valid), 0);
    chk("ack_conv_rst", 32'(conv_rst), 1);
    chk("ack_s_ready", 32'(s_ready), 1);
    chk("ack_retained_el3", el1(3), 32'h103);
    cnt_base = 1;
`endif

    // Early last on beat 9, then a good frame
    for (int i = 0; i < 10; i++) beat(32'h300 + 32'(i), i == 9);
    chk("early_frame_err", 32'(frame_err), 1);
    chk("early_img_valid", 32'(img_valid), 0);
    chk("early_conv_rst", 32'(conv_rst), 1);
    chk("early_frame_cnt", 32'(frame_cnt), 32'(cnt_base));
    chk("early_el9_written", el1(9), 32'h309);
    pulse_ack();
    chk("fill_ack_ignored_valid", 32'(img_valid), 0);
    chk("fill_ack_ignored_ready", 32'(s_ready), 1);
    for (int i = 0; i < 16; i++) beat(32'h200 + 32'(i), i == 15);
    chk("f2_el0", el1(0), 32'h200);
    chk("f2_el9", el1(9), 32'h209);
    chk("f2_el15", el1(15), 32'h20F);
    chk("f2_frame_cnt", 32'(frame_cnt), 32'(cnt_base + 1));
    chk("f2_img_valid", 32'(img_valid), 1);
    pulse_ack();
    chk("f2_ack_valid", 32'(img_valid), 0);

    // Missing s_last: frame still completes but flags an error
    do_reset();
    chk("nolast_pre_err", 32'(frame_err), 0);
    for (int i = 0; i < 16; i++) beat(32'h800 + 32'(i), 1'b0);
    chk("nolast_img_valid", 32'(img_valid), 1);
    chk("nolast_frame_err", 32'(frame_err), 1);
    chk("nolast_frame_cnt", 32'(frame_cnt), 1);
    chk("nolast_el7", el1(7), 32'h807);
    pulse_ack();

    // Reset mid-frame after 7 beats, then a full frame
    for (int i = 0; i < 7; i++) beat(32'h400 + 32'(i), 1'b0);
    do_reset();
    chk("midrst_frame_cnt", 32'(frame_cnt), 0);
    chk("midrst_el0", el1(0), 0);
    chk("midrst_img_valid", 32'(img_valid), 0);
    for (int i = 0; i < 16; i++) beat(32'h500 + 32'(i), i == 15);
    for (int i = 0; i < 16; i++) chk("midrst_elem", el1(i), 32'h500 + 32'(i));
    chk("midrst_frame_cnt_after", 32'(frame_cnt), 1);
    chk("midrst_frame_err", 32'(frame_err), 0);
    chk("midrst_img_valid_after", 32'(img_valid), 1);

    // D=2 instance with random valid gaps
    k = 0;
    cyc = 0;
    while (k < 32 && cyc < 500) begin
      s_valid2 = 1'($urandom_range(0, 1));
      s_data2  = 32'h600 + 32'(k);
      s_last2  = (k == 31);
      acc = s_valid2 && s_ready2;
      step();
      cyc++;
      if (acc) k++;
    end
    s_valid2 = 1'b0;
    chk("d2_beats_accepted", 32'(k), 32);
    chk("d2_img_valid", 32'(img_valid2), 1);
    chk("d2_conv_rst", 32'(conv_rst2), 0);
    chk("d2_frame_cnt", 32'(frame_cnt2), 1);
    chk("d2_frame_err", 32'(frame_err2), 0);
    chk("d2_ch1_first", el2(16), 32'h610);
    for (int i = 0; i < 32; i++) chk("d2_elem", el2(i), 32'h600 + 32'(i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
